// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32 decode constants: immediate select encoding, opcodes, NOP
// Shared by if_fetch_queue (predecode) and imm_gen (immediate expansion) so the
// select code produced in fetch is consumed unchanged downstream.
package rv_pkg;

  typedef enum logic [2:0] {
    IMM_I       = 3'b000,
    IMM_S       = 3'b001,
    IMM_B       = 3'b010,
    IMM_J       = 3'b011,
    IMM_U_LUI   = 3'b100,
    IMM_U_AUIPC = 3'b101,
    IMM_NONE    = 3'b111
  } imm_sel_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - parameterised synchronous FIFO with push/pop/flush and occupancy count
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_push, i_push_data    write one entry at the tail
//   i_pop                  retire the head entry
//   i_flush                empty the FIFO; overrides push and pop in the same cycle
//   o_head_data            current head entry (stale when o_count == 0)
//   o_count                number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// The owner guarantees no push when full and no pop when empty.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_head_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (i_push) begin
        mem_d[wptr_q] = i_push_data;
        wptr_d        = wptr_q + PTR_W'(1);
      end
      if (i_pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign o_head_data = mem_q[rptr_q];
  assign o_count     = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage: PC, in-order imem requests, buffered predecoded output
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   o_imem_req/o_imem_addr          fetch request and word-aligned address
//   i_imem_gnt                      request accepted this cycle
//   i_imem_rvalid/i_imem_rdata      in-order response, earliest the cycle after grant
//   i_redirect_valid/i_redirect_pc  single-cycle redirect (branch/jump/trap)
//   o_inst_valid/i_inst_ready       decode handshake on the buffer head
//   o_inst/o_pc/o_imm_sel           head instruction, its PC, predecoded imm select
//   o_misalign                      only with IF_MISALIGN_EXC_EN: halted on a misaligned target
// Build option IF_MISALIGN_EXC_EN: a misaligned redirect target halts fetch and
// presents a NOP at the raw target with o_misalign set until the next aligned
// redirect. Without it the low two target bits are silently cleared.
module if_fetch_queue
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [2:0]  o_imm_sel
`ifdef IF_MISALIGN_EXC_EN
  ,
  output logic        o_misalign
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  // Total in flight is live plus dropped requests; several redirects with a
  // slow memory can stack dropped ones beyond FIFO_DEPTH, hence the headroom.
  localparam int OUT_W = 8;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [OUT_W-1:0] live_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic [63:0]      fifo_head;
  logic [31:0]      head_pc, head_inst;
  logic [31:0]      redirect_pc_al;
  logic             grant, fifo_push, fifo_pop, halt;
  imm_sel_e         head_sel;

  assign redirect_pc_al = {i_redirect_pc[31:2], 2'b00};
  assign live_cnt       = outstanding_q - drop_cnt_q;

  // Each live request and each buffered word owns one FIFO slot, so a response
  // can always be pushed. Gated by reset so the request is low during reset.
  assign o_imem_req  = i_rst_n && !i_redirect_valid && !halt &&
                       ((live_cnt + OUT_W'(fifo_count)) < OUT_W'(FIFO_DEPTH));
  assign o_imem_addr = pc_q;
  assign grant       = o_imem_req && i_imem_gnt;
  assign fifo_push   = i_imem_rvalid && (drop_cnt_q == '0) && !i_redirect_valid;
  assign fifo_pop    = (fifo_count != '0) && i_inst_ready && !i_redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + OUT_W'(grant) - OUT_W'(i_imem_rvalid);
    if (i_redirect_valid) begin
      pc_d       = redirect_pc_al;
      resp_pc_d  = redirect_pc_al;
      // Everything still in flight after this cycle belongs to the old path.
      drop_cnt_d = outstanding_q - OUT_W'(i_imem_rvalid);
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (i_imem_rvalid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - OUT_W'(1);
        end else begin
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef IF_MISALIGN_EXC_EN
  logic        halt_q, halt_d;
  logic [31:0] halt_pc_q, halt_pc_d;

  always_comb begin
    halt_d    = halt_q;
    halt_pc_d = halt_pc_q;
    if (i_redirect_valid) begin
      halt_d    = (i_redirect_pc[1:0] != 2'b00);
      halt_pc_d = i_redirect_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      halt_q    <= 1'b0;
      halt_pc_q <= '0;
    end else begin
      halt_q    <= halt_d;
      halt_pc_q <= halt_pc_d;
    end
  end

  assign halt       = halt_q;
  assign o_misalign = halt_q;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
  assign halt                 = 1'b0;
`endif

  if_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (fifo_push),
    .i_push_data({resp_pc_q, i_imem_rdata}),
    .i_pop      (fifo_pop),
    .i_flush    (i_redirect_valid),
    .o_head_data(fifo_head),
    .o_count    (fifo_count)
  );

  assign head_pc   = fifo_head[63:32];
  assign head_inst = fifo_head[31:0];

  always_comb begin
    head_sel = IMM_NONE;
    case (head_inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: head_sel = IMM_I;
      OPC_STORE:                      head_sel = IMM_S;
      OPC_BRANCH:                     head_sel = IMM_B;
      OPC_JAL:                        head_sel = IMM_J;
      OPC_LUI:                        head_sel = IMM_U_LUI;
      OPC_AUIPC:                      head_sel = IMM_U_AUIPC;
      default:                        head_sel = IMM_NONE;
    endcase
  end

  // Outputs read as zero / IMM_NONE whenever the buffer is empty, which also
  // gives the required reset values.
  always_comb begin
    o_inst_valid = (fifo_count != '0);
    o_pc         = o_inst_valid ? head_pc : 32'h0;
    o_inst       = o_inst_valid ? head_inst : 32'h0;
    o_imm_sel    = o_inst_valid ? head_sel : IMM_NONE;
`ifdef IF_MISALIGN_EXC_EN
    if (halt_q) begin
      o_inst_valid = 1'b1;
      o_pc         = halt_pc_q;
      o_inst       = NOP_INST;
      o_imm_sel    = IMM_I;
    end
`endif
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue with a queue-based fetch model
module tb_if_fetch_queue;
  import rv_pkg::*;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;
`ifdef IF_MISALIGN_EXC_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt, i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_inst_valid, i_inst_ready;
  logic [31:0] o_inst, o_pc;
  logic [2:0]  o_imm_sel;
`ifdef IF_MISALIGN_EXC_EN
  logic        o_misalign;
`endif

  always #5 clk = ~clk;

  if_fetch_queue #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
    .o_inst(o_inst), .o_pc(o_pc), .o_imm_sel(o_imm_sel)
`ifdef IF_MISALIGN_EXC_EN
    , .o_misalign(o_misalign)
`endif
  );

  typedef struct { logic [31:0] addr; bit drop; int cyc; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] rdata; logic [2:0] exp_sel; } vec_t;

  req_t        pend[$];
  ent_t        mfifo[$];
  vec_t        tbl[10];
  logic [31:0] mpc, mhalt_pc;
  bit          mhalt, use_tbl;
  int          cyc, vectors, miscompares, dut_grants, nseen;
  bit          found;

  function automatic logic [2:0] ref_sel(input logic [31:0] w);
    case (w[6:0])
      7'h13, 7'h03, 7'h67: return 3'b000;
      7'h23: return 3'b001;
      7'h63: return 3'b010;
      7'h6F: return 3'b011;
      7'h37: return 3'b100;
      7'h17: return 3'b101;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] opc;
    int idx;
    if (use_tbl) begin
      idx = int'(((a - RPC) >> 2) % 32'd10);
      return tbl[idx].rdata;
    end
    case (a[4:2])
      3'd0: opc = 7'h13;
      3'd1: opc = 7'h37;
      3'd2: opc = 7'h6F;
      3'd3: opc = 7'h63;
      3'd4: opc = 7'h33;
      3'd5: opc = 7'h23;
      3'd6: opc = 7'h17;
      default: opc = 7'h03;
    endcase
    return {a[26:2] ^ 25'h0ABCDEF, opc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Entered at posedge+1; drives one cycle, checks at posedge+3, then advances the model.
  task automatic cycle(input bit rd, input logic [31:0] rpc, input bit g, input bit r, input bit rv_want);
    bit   rv, exp_req, req_seen;
    int   live;
    req_t h;
    int   idx;
    rv = rv_want && pend.size() > 0 && pend[0].cyc < cyc;
    i_redirect_valid = rd; i_redirect_pc = rpc; i_imem_gnt = g; i_inst_ready = r;
    i_imem_rvalid = rv;
    i_imem_rdata = 32'hDEAD_BEEF;
    if (rv) i_imem_rdata = mem_word(pend[0].addr);
    #2;
    live = 0;
    foreach (pend[k]) if (!pend[k].drop) live++;
    exp_req = !rd && !mhalt && (live + mfifo.size() < DEPTH);
    chk("imem_req", o_imem_req, exp_req);
    if (exp_req) chk("imem_addr", o_imem_addr, mpc);
    if (mhalt) begin
      chk("halt_valid", o_inst_valid, 1);
      chk("halt_pc", o_pc, mhalt_pc);
      chk("halt_inst", o_inst, NOP_INST);
      chk("halt_sel", o_imm_sel, 3'b000);
    end else begin
      chk("inst_valid", o_inst_valid, mfifo.size() != 0);
      if (mfifo.size() != 0) begin
        chk("o_pc", o_pc, mfifo[0].pc);
        chk("o_inst", o_inst, mfifo[0].inst);
        chk("o_imm_sel", o_imm_sel, ref_sel(mfifo[0].inst));
        if (use_tbl) begin
          idx = int'(((mfifo[0].pc - RPC) >> 2) % 32'd10);
          chk("tbl_imm_sel", o_imm_sel, tbl[idx].exp_sel);
        end
      end
    end
`ifdef IF_MISALIGN_EXC_EN
    chk("misalign", o_misalign, mhalt);
`endif
    req_seen = o_imem_req && g;
    if (req_seen) dut_grants++;
    @(posedge clk); #1;
    if (rd) begin
      if (rv) void'(pend.pop_front());
      foreach (pend[k]) pend[k].drop = 1'b1;
      mfifo.delete();
      mhalt    = MIS_EN && (rpc[1:0] != 2'b00);
      mhalt_pc = rpc;
      mpc      = {rpc[31:2], 2'b00};
    end else begin
      if (mfifo.size() != 0 && r) void'(mfifo.pop_front());
      if (rv) begin
        h = pend.pop_front();
        if (!h.drop) mfifo.push_back('{h.addr, mem_word(h.addr)});
      end
      if (req_seen) begin
        pend.push_back('{mpc, 1'b0, cyc});
        mpc = mpc + 32'd4;
      end
      chk("no_overflow", mfifo.size() <= DEPTH, 1);
    end
    cyc++;
  endtask

  // Entered at posedge+1; reset asserts between edges so the checks see the async path.
  task automatic do_reset();
    i_rst_n = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0; i_imem_gnt = 1'b1;
    i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_inst_ready = 1'b1;
    #2;
    chk("rst_req", o_imem_req, 0);
    chk("rst_valid", o_inst_valid, 0);
    chk("rst_inst", o_inst, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_imm_sel", o_imm_sel, 3'b111);
`ifdef IF_MISALIGN_EXC_EN
    chk("rst_misalign", o_misalign, 0);
`endif
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    pend.delete(); mfifo.delete();
    mpc = RPC; mhalt = 1'b0; mhalt_pc = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h0050_0093, 3'b000};
    tbl[1] = '{32'h0000_0037, 3'b100};
    tbl[2] = '{32'h0000_006F, 3'b011};
    tbl[3] = '{32'h0000_0063, 3'b010};
    tbl[4] = '{32'h0000_0033, 3'b111};
    tbl[5] = '{32'h0000_0023, 3'b001};
    tbl[6] = '{32'h0000_0017, 3'b101};
    tbl[7] = '{32'h0000_0003, 3'b000};
    tbl[8] = '{32'h0000_0067, 3'b000};
    tbl[9] = '{32'h0000_007F, 3'b111};
    vectors = 0; miscompares = 0; cyc = 0; dut_grants = 0;
    i_rst_n = 1'b0;
    @(posedge clk); #1;

    // Reset, table-driven predecode, PC sequence and first-response latency.
    use_tbl = 1'b1;
    do_reset();
    nseen = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_inst_valid) begin
        if (nseen == 0) chk("first_valid_cycle", i, 2);
        chk("pc_seq", o_pc, RPC + 32'(4 * nseen));
        nseen++;
      end
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    end
    use_tbl = 1'b0;

    // Decode stalled for 10 cycles: exactly DEPTH grants, then in-order drain.
    cycle(1'b1, RPC, 1'b0, 1'b0, 1'b0);
    dut_grants = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("stall_grants", dut_grants, DEPTH);
    chk("stall_req_off", o_imem_req, 0);
    chk("drain_first_pc", o_pc, RPC);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Redirect with two requests outstanding and one response in the same cycle.
    for (int i = 0; i < 30 && (pend.size() != 0 || mfifo.size() != 0); i++)
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("drain_timeout", pend.size() + mfifo.size(), 0);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    chk("flush_empty", o_inst_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (o_inst_valid) begin
        chk("redirect_first_pc", o_pc, 32'h200);
        found = 1'b1;
      end else begin
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
      end
    end
    chk("redirect_first_pc_seen", found, 1);

    // PC wraps from the top of the address space.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("wrap_addr", o_imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Misaligned redirect target.
    cycle(1'b1, 32'h202, 1'b1, 1'b1, 1'b1);
`ifdef IF_MISALIGN_EXC_EN
    chk("misalign_set", o_misalign, 1);
    chk("misalign_raw_pc", o_pc, 32'h202);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
    chk("halt_clear", o_misalign, 0);
    chk("halt_clear_addr", o_imem_addr, 32'h300);
`else
    chk("misalign_restart_addr", o_imem_addr, 32'h200);
`endif
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 19) == 0, $urandom & 32'h0000_3FFF,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

    // Reset asserted mid-burst, then fetch restarts from RESET_PC.
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    do_reset();
    chk("post_reset_addr", o_imem_addr, RPC);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly upstream of decode and imm_gen.
- Owns the PC and issues in-order requests to instruction memory.
- Buffers returned words in a small FIFO and presents {pc, inst, imm_sel} to decode with a valid/ready handshake.
- The predecoded imm_sel follows the imm_gen select encoding, so decode forwards it unchanged.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, 2..8.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- o_imem_req  out  1  fetch request valid
- o_imem_addr  out  32  fetch address, word aligned
- i_imem_gnt  in  1  request accepted this cycle
- i_imem_rvalid  in  1  response data valid; responses return in order, never earlier than the cycle after grant
- i_imem_rdata  in  32  instruction word
- i_redirect_valid  in  1  branch/jump/trap redirect, single-cycle pulse
- i_redirect_pc  in  32  redirect target
- o_inst_valid  out  1  FIFO head valid
- i_inst_ready  in  1  decode accepts head
- o_inst  out  32  instruction
- o_pc  out  32  PC of o_inst
- o_imm_sel  out  3  predecoded immediate select

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty; outstanding=0, drop_cnt=0.
  - o_imem_req=0, o_inst_valid=0; o_inst, o_pc=0; o_imm_sel=3'b111.
- Credit rule:
  - o_imem_req=1 iff no redirect this cycle and (outstanding + fifo_count) < FIFO_DEPTH, counting only non-dropped outstanding.
  - This guarantees the FIFO never overflows; the bench asserts it.
- Address: o_imem_addr = pc.
- Grant: on o_imem_req && i_imem_gnt, pc <= pc+4 (mod 2^32 wrap) and outstanding++.
- Response: on i_imem_rvalid, outstanding--.
  - If drop_cnt>0, drop_cnt-- and discard the word.
  - Otherwise push {resp_pc, rdata} and resp_pc <= resp_pc+4.
- Pop: on o_inst_valid && i_inst_ready. Push and pop in the same cycle are both allowed, count unchanged.
- Output: o_inst_valid = (fifo_count != 0); o_inst/o_pc/o_imm_sel driven from the FIFO head.
- Latency: grant in cycle N, rvalid in N+1, o_inst_valid in N+2 (no bypass).
- Redirect (i_redirect_valid=1) takes priority over everything else in that cycle:
  - FIFO flushed, any pop ignored.
  - pc and resp_pc <= {i_redirect_pc[31:2], 2'b00}.
  - drop_cnt <= outstanding − (i_imem_rvalid ? 1 : 0); a response arriving in the redirect cycle is discarded.
  - o_imem_req=0 in the redirect cycle; fetch restarts the next cycle.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Stalled decode (ready=0): FIFO fills and credit blocks new requests. Head and all outputs stay stable while valid && !ready.
- o_imm_sel predecode from opcode inst[6:0]:
  - 0010011, 0000011, 1100111 → 000
  - 0100011 → 001
  - 1100011 → 010
  - 1101111 → 011
  - 0110111 → 100
  - 0010111 → 101
  - any other opcode → 111 (no immediate)

Optional Feature:
- IF_MISALIGN_EXC_EN defined:
  - A redirect with i_redirect_pc[1:0]!=0 flushes as normal and enters HALT; no requests are issued.
  - Adds output o_misalign (1 bit, reset 0), asserted in HALT alongside o_inst_valid=1, o_pc=raw target, o_inst=32'h0000_0013 (NOP), o_imm_sel=000.
  - HALT persists across handshakes; only the next aligned redirect clears it.
- Not defined: low two target bits are forced to 0 silently; no o_misalign port.

Decomposition:
- Shared package rv_pkg: imm_sel_e enum (IMM_I=000, IMM_S=001, IMM_B=010, IMM_J=011, IMM_U_LUI=100, IMM_U_AUIPC=101, IMM_NONE=111), the opcode constants, and NOP_INST. imm_gen imports the same package.
- One sub-module, if_fifo: a parameterised sync FIFO with push/pop/flush/count.
- Predecode logic stays inline in if_fetch_queue.

Test Plan:
- Reset with RESET_PC=0x100, mem gnt=1, rvalid one cycle later, ready=1:
  - o_pc sequence 0x100, 0x104, 0x108.
  - First o_inst_valid two cycles after the first grant.
- Return rdata=0x00500093 (addi):
  - o_imm_sel=000.
  - 0x00000037 → 100, 0x0000006F → 011, 0x00000063 → 010, 0x00000033 → 111.
- Hold ready=0 for 10 cycles:
  - Exactly FIFO_DEPTH grants occur, then o_imem_req=0.
  - Outputs stable; no overflow.
  - Release ready: in-order drain, 0x100 first.
- Redirect to 0x200 with 2 requests outstanding, one rvalid in the same cycle:
  - All 2 responses discarded; next o_pc=0x200; FIFO empty the cycle after redirect.
- pc=0xFFFFFFFC, gnt=1: next o_imem_addr=0x00000000.
- Redirect to 0x202:
  - Macro off: fetch restarts from 0x200.
  - Macro on: o_misalign=1 and no requests issued; a later redirect to 0x300 clears HALT and fetch restarts from 0x300.
  - Assert i_rst_n=0 mid-burst: all outputs return to their reset values asynchronously.
